b_recv_fsm: RTL



---
 rtl/b_recv_fsm.sv | 102 ++++++++++
 1 files changed

// File: rtl/b_recv_fsm.sv
// Receive side of the MCP CDC handshake (b domain): syncs the load toggle, captures the held
// a-domain word, presents it with valid/ready and returns an ack toggle. Optional overrun flag: B_RECV_OVERRUN_EN.
module b_recv_fsm #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          bclk,
  input  logic          brst,
  input  logic          bload_tgl,
  input  logic [DW-1:0] bdata_in,
  output logic          back_tgl,
  output logic          bvalid,
  input  logic          bready,
  output logic [DW-1:0] bdata,
  output logic          berr
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   bload_pulse;

  state_e                 state_q, state_d;
  logic [DW-1:0]          bdata_q, bdata_d;
  logic                   ack_q, ack_d;

  // Toggle synchronizer; the history flop turns each level change into a one-cycle pulse.
  always_ff @(posedge bclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (brst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bload_tgl};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign bload_pulse = sync_q[SYNC_STAGES-1] ^ hist_q;

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned, which would infer a latch.
    state_d = state_q;
    bdata_d = bdata_q;
    ack_d   = ack_q;
    unique case (state_q)
      IDLE: begin
        if (bload_pulse) begin
          state_d = FULL;
          bdata_d = bdata_in;
        end
      end
      FULL: begin
        // A pulse seen here is an overrun: the held word stays and the new one is dropped.
        if (bready) begin
          state_d = IDLE;
          ack_d   = ~ack_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bclk) begin
    if (brst) begin
      state_q <= IDLE;
      // NOTE: the data register is reset because a reset must discard any held word visibly.
      bdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bdata_q <= bdata_d;
      ack_q   <= ack_d;
    end
  end

  assign bvalid   = (state_q == FULL);
  assign bdata    = bdata_q;
  assign back_tgl = ack_q;

`ifdef B_RECV_OVERRUN_EN
  logic berr_q;

  // Sticky until reset: the sender advanced without waiting for our ack.
  always_ff @(posedge bclk) begin
    if (brst) begin
      berr_q <= 1'b0;
    end else if ((state_q == FULL) && bload_pulse) begin
      berr_q <= 1'b1;
    end
  end

  assign berr = berr_q;
`else
  assign berr = 1'b0;
`endif

endmodule
